rc4_crypt_engine: RTL and testbench
===================================

RC4_CRYPT_ENGINE -- requirements
Module: rc4_crypt_engine

Interface
REQ-001 Parameter DEPTH, default 256, S-memory entries; power of two, 16..256.
REQ-002 Parameter KEY_BYTES, default 3, secret key length in bytes, 1..16.
REQ-003 Parameter MSG_LEN, default 32, message bytes processed by PRGA, 1..256.
REQ-004 Parameter AW, default $clog2(DEPTH), S-memory address width.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle request; sampled only in IDLE.
REQ-008 prga_en  input  1  sampled with start; 1 = run PRGA after KSA, 0 = stop after KSA.
REQ-009 secret_key  input  8*KEY_BYTES  key; byte 0 is the most significant byte.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse on completion.
REQ-012 s_addr / s_wdata / s_we  output  AW / 8 / 1  S-memory port; s_rdata (input, 8) is valid one cycle after the address is presented.
REQ-013 rom_addr  output  8  ciphertext ROM address; rom_rdata (input, 8) is valid one cycle after rom_addr.
REQ-014 out_addr / out_wdata / out_we  output  8 / 8 / 1  result RAM write port.

Function
REQ-015 FSM states: IDLE, INIT, KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J, P_RD_I, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J, P_RD_F, P_WT_F, P_WR_O, DONE.
REQ-016 IDLE->INIT on start; secret_key and prga_en latched on that edge; i, j cleared.
REQ-017 INIT writes S[i]=i, one write per cycle, i=0..DEPTH-1; exactly DEPTH cycles; then KSA_RD_I with i=0.
REQ-018 KSA per iteration: read S[i]; j = j + S[i] + key[i mod KEY_BYTES] (mod DEPTH); read S[j]; write S[i]=old S[j]; write S[j]=old S[i]; 6 cycles per iteration; i=0..DEPTH-1.
REQ-019 When i==j both writes carry the same value; no special casing.
REQ-020 After the last KSA iteration: DONE if prga_en=0, else P_RD_I with i=0, j=0, k=0.
REQ-021 PRGA per byte k: i=i+1; j=j+S[i]; swap as in REQ-018; in P_RD_F, drive s_addr=(S[i]+S[j]) mod DEPTH and rom_addr=k; in P_WR_O, write out[k]=s_rdata XOR rom_rdata; 9 cycles per byte; k=0..MSG_LEN-1.
REQ-022 All index arithmetic wraps modulo DEPTH; k wraps never (terminates at MSG_LEN-1).
REQ-023 Latency: done pulses exactly 1 + 7*DEPTH + (prga_en ? 9*MSG_LEN : 0) cycles after the start-accept edge.
REQ-024 DONE drives done=1 for one cycle, then returns to IDLE.
REQ-025 start while busy is ignored; latched key is not updated.
REQ-026 s_we and out_we are high only in write states; addresses and data hold their last values otherwise.

Reset
REQ-027 Reset forces IDLE; busy, done, s_we, and out_we are 0; all addresses, data, i, j, and k are 0.
REQ-028 Reset mid-operation aborts immediately; no further memory write occurs; the next start restarts from INIT.

Structure
REQ-029 Package rc4_pkg holds the state enum, the default DEPTH/KEY_BYTES/MSG_LEN constants, and the key-byte select function.
REQ-030 Sub-module rc4_swap_unit implements the shared 6-cycle read-read-write-write swap sequence; KSA and PRGA both use it.

Verification
REQ-031 Init: DEPTH=256, start, prga_en=0 -> 256 consecutive writes with S[n]=n; first KSA read at S[0].
REQ-032 KSA key 24'h000000 -> iterations i=0,1 are self-swaps (j=0, 1); i=2 swaps S[2] and S[3] (j=3); final S matches the C model.
REQ-033 KSA-only latency: DEPTH=256, prga_en=0 -> done at exactly cycle 1793 after start; busy is high throughout.
REQ-034 PRGA: key 24'h000000, MSG_LEN=32, ROM=model ciphertext -> out[0..31] equals the model plaintext; done at cycle 2081.
REQ-035 Reset asserted at cycle 500 of KSA -> outputs reach 0 asynchronously; no s_we afterwards; a new start completes correctly.
REQ-036 Parameter sweep: DEPTH=16, KEY_BYTES=5, start pulsed again while busy -> second start is ignored; the result matches the model.

Source files
------------

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state/op encodings, default sizes and key-byte select for the RC4 engine
package rc4_pkg;

    localparam int DEPTH_DEF     = 256;
    localparam int KEY_BYTES_DEF = 3;
    localparam int MSG_LEN_DEF   = 32;
    localparam int KEY_W         = 128;

    typedef enum logic [4:0] {
        IDLE, INIT,
        KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
        P_RD_I, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J,
        P_RD_F, P_WT_F, P_WR_O,
        DONE
    } rc4_state_e;

    typedef enum logic [2:0] {
        OP_NONE, OP_FILL, OP_RD_I, OP_RD_J, OP_WR_I, OP_WR_J, OP_RD_F
    } swap_op_e;

    // Byte 0 of the key is the most significant byte of the nbytes-wide key.
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] key,
                                            input int unsigned nbytes,
                                            input int unsigned pos);
        int unsigned      sel;
        logic [KEY_W-1:0] sh;
        sel = pos % nbytes;
        sh  = key >> (8 * (nbytes - 1 - sel));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/rc4_swap_unit.sv
// rtl/rc4_swap_unit.sv - S-memory port driver: fill, read S[i], read S[j], write back swapped, final lookup
module rc4_swap_unit
    import rc4_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  swap_op_e      op,
    input  logic          j_clr,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    j_add,
    input  logic [7:0]    s_rdata,
    output logic [AW-1:0] s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_we
);

    logic [AW-1:0] j;
    logic [AW-1:0] j_next;
    logic [AW-1:0] f_addr;
    logic [7:0]    si;
    logic [7:0]    sj;
    logic [7:0]    f_sum;

    assign j_next = j + s_rdata[AW-1:0] + j_add[AW-1:0];
    assign f_sum  = si + sj;
    assign f_addr = f_sum[AW-1:0];

    // Outputs are registered, so each op shows up on the port one cycle after it is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_addr  <= '0;
            s_wdata <= 8'd0;
            s_we    <= 1'b0;
            j       <= '0;
            si      <= 8'd0;
            sj      <= 8'd0;
        end else begin
            case (op)
                OP_FILL: begin
                    s_addr  <= idx;
                    s_wdata <= 8'(idx);
                    s_we    <= 1'b1;
                end
                OP_RD_I: begin
                    s_addr <= idx;
                    s_we   <= 1'b0;
                end
                OP_RD_J: begin
                    si     <= s_rdata;
                    j      <= j_next;
                    s_addr <= j_next;
                    s_we   <= 1'b0;
                end
                OP_WR_I: begin
                    sj      <= s_rdata;
                    s_addr  <= idx;
                    s_wdata <= s_rdata;
                    s_we    <= 1'b1;
                end
                OP_WR_J: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    s_we    <= 1'b1;
                end
                OP_RD_F: begin
                    s_addr <= f_addr;
                    s_we   <= 1'b0;
                end
                default: s_we <= 1'b0;
            endcase
            if (j_clr) begin
                j <= '0;
            end
        end
    end

endmodule

// File: rtl/rc4_crypt_engine.sv
// rtl/rc4_crypt_engine.sv - RC4 sequencer: S init, key schedule, optional keystream XOR of a ROM message
module rc4_crypt_engine
    import rc4_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int MSG_LEN   = MSG_LEN_DEF,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   prga_en,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_we,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             rom_addr,
    input  logic [7:0]             rom_rdata,
    output logic [7:0]             out_addr,
    output logic [7:0]             out_wdata,
    output logic                   out_we
);

    localparam logic [AW-1:0] I_LAST = AW'(DEPTH - 1);
    localparam logic [7:0]    K_LAST = 8'(MSG_LEN - 1);

    rc4_state_e             state;
    logic [AW-1:0]          i;
    logic [7:0]             k;
    logic [8*KEY_BYTES-1:0] key_q;
    logic                   prga_q;
    logic [KEY_W-1:0]       key_wide;
    logic [7:0]             kb;

    swap_op_e      op;
    logic [AW-1:0] idx;
    logic [7:0]    j_add;
    logic          j_clr;

    assign key_wide = KEY_W'(key_q);
    assign kb       = key_byte(key_wide, KEY_BYTES, 32'(i));

    always_comb begin
        op    = OP_NONE;
        idx   = i;
        j_add = 8'd0;
        j_clr = 1'b0;
        case (state)
            IDLE: if (start) begin
                op    = OP_FILL;
                idx   = '0;
                j_clr = 1'b1;
            end
            INIT: if (i != I_LAST) begin
                op  = OP_FILL;
                idx = i + AW'(1);
            end
            KSA_RD_I: op = OP_RD_I;
            KSA_RD_J: begin
                op    = OP_RD_J;
                j_add = kb;
            end
            KSA_WR_I: op = OP_WR_I;
            KSA_WR_J: begin
                op    = OP_WR_J;
                j_clr = (i == I_LAST);
            end
            // PRGA pre-increments i before reading S[i]
            P_RD_I: begin
                op  = OP_RD_I;
                idx = i + AW'(1);
            end
            P_RD_J: op = OP_RD_J;
            P_WR_I: op = OP_WR_I;
            P_WR_J: op = OP_WR_J;
            P_RD_F: op = OP_RD_F;
            default: ;
        endcase
    end

    rc4_swap_unit #(.AW(AW)) u_swap (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .j_clr   (j_clr),
        .idx     (idx),
        .j_add   (j_add),
        .s_rdata (s_rdata),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_we    (s_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            i         <= '0;
            k         <= 8'd0;
            key_q     <= '0;
            prga_q    <= 1'b0;
            rom_addr  <= 8'd0;
            out_addr  <= 8'd0;
            out_wdata <= 8'd0;
            out_we    <= 1'b0;
        end else begin
            done   <= 1'b0;
            out_we <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= INIT;
                    busy   <= 1'b1;
                    key_q  <= secret_key;
                    prga_q <= prga_en;
                    i      <= '0;
                    k      <= 8'd0;
                end
                INIT: begin
                    if (i == I_LAST) begin
                        i     <= '0;
                        state <= KSA_RD_I;
                    end else begin
                        i <= i + AW'(1);
                    end
                end
                KSA_RD_I: state <= KSA_WT_I;
                KSA_WT_I: state <= KSA_RD_J;
                KSA_RD_J: state <= KSA_WT_J;
                KSA_WT_J: state <= KSA_WR_I;
                KSA_WR_I: state <= KSA_WR_J;
                KSA_WR_J: begin
                    if (i == I_LAST) begin
                        i     <= '0;
                        k     <= 8'd0;
                        state <= prga_q ? P_RD_I : DONE;
                    end else begin
                        i     <= i + AW'(1);
                        state <= KSA_RD_I;
                    end
                end
                P_RD_I: begin
                    i     <= i + AW'(1);
                    state <= P_WT_I;
                end
                P_WT_I: state <= P_RD_J;
                P_RD_J: state <= P_WT_J;
                P_WT_J: state <= P_WR_I;
                P_WR_I: state <= P_WR_J;
                P_WR_J: state <= P_RD_F;
                P_RD_F: begin
                    rom_addr <= k;
                    state    <= P_WT_F;
                end
                P_WT_F: state <= P_WR_O;
                P_WR_O: begin
                    out_addr  <= k;
                    out_wdata <= s_rdata ^ rom_rdata;
                    out_we    <= 1'b1;
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 8'd1;
                        state <= P_RD_I;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_crypt_engine.sv
// tb/tb_rc4_crypt_engine.sv - directed/randomized bench for rc4_crypt_engine against a textbook RC4 model
module tb_rc4_crypt_engine;

    localparam int DA = 256, KA = 3, MA = 32;
    localparam int DB = 16,  KB = 5, MB = 8;
    localparam int TR = 2200;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_a, prga_a, busy_a, done_a, s_we_a, out_we_a;
    logic [23:0] key_a;
    logic [7:0]  s_addr_a, s_wdata_a, s_rdata_a, rom_addr_a, rom_rdata_a, out_addr_a, out_wdata_a;

    logic        start_b, prga_b, busy_b, done_b, s_we_b, out_we_b;
    logic [39:0] key_b;
    logic [3:0]  s_addr_b;
    logic [7:0]  s_wdata_b, s_rdata_b, rom_addr_b, rom_rdata_b, out_addr_b, out_wdata_b;

    rc4_crypt_engine #(.DEPTH(DA), .KEY_BYTES(KA), .MSG_LEN(MA)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .prga_en(prga_a), .secret_key(key_a),
        .busy(busy_a), .done(done_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_we(s_we_a),
        .s_rdata(s_rdata_a), .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a),
        .out_addr(out_addr_a), .out_wdata(out_wdata_a), .out_we(out_we_a)
    );

    rc4_crypt_engine #(.DEPTH(DB), .KEY_BYTES(KB), .MSG_LEN(MB)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .prga_en(prga_b), .secret_key(key_b),
        .busy(busy_b), .done(done_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_we(s_we_b),
        .s_rdata(s_rdata_b), .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
        .out_addr(out_addr_b), .out_wdata(out_wdata_b), .out_we(out_we_b)
    );

    logic [7:0] smem_a [DA];
    logic [7:0] rom_a  [256];
    logic [7:0] outm_a [256];
    logic [7:0] smem_b [DB];
    logic [7:0] rom_b  [256];
    logic [7:0] outm_b [256];

    always @(posedge clk) begin
        if (s_we_a) smem_a[s_addr_a] <= s_wdata_a;
        s_rdata_a   <= smem_a[s_addr_a];
        rom_rdata_a <= rom_a[rom_addr_a];
        if (out_we_a) outm_a[out_addr_a] <= out_wdata_a;
        if (s_we_b) smem_b[s_addr_b] <= s_wdata_b;
        s_rdata_b   <= smem_b[s_addr_b];
        rom_rdata_b <= rom_b[rom_addr_b];
        if (out_we_b) outm_b[out_addr_b] <= out_wdata_b;
    end

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference RC4: plain arrays, S after KSA (+PRGA swaps) in ms, keystream in mks.
    int ms  [256];
    int mks [256];
    task automatic rc4_model(input int depth, input int nkey, input logic [127:0] key, input int msglen);
        int kb [16];
        int i, j, t;
        logic [127:0] tmp;
        for (int b = 0; b < nkey; b++) begin
            tmp   = key >> (8 * (nkey - 1 - b));
            kb[b] = int'(tmp[7:0]);
        end
        for (int n = 0; n < depth; n++) ms[n] = n;
        j = 0;
        for (int n = 0; n < depth; n++) begin
            j = (j + ms[n] + kb[n % nkey]) % depth;
            t = ms[n]; ms[n] = ms[j]; ms[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < msglen; k++) begin
            i = (i + 1) % depth;
            j = (j + ms[i]) % depth;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            mks[k] = ms[(ms[i] + ms[j]) % depth];
        end
    endtask

    logic [7:0] pt_a [256];
    logic [7:0] pt_b [256];

    task automatic load_rom_a();
        for (int k = 0; k < MA; k++) begin
            pt_a[k]  = 8'($urandom);
            rom_a[k] = pt_a[k] ^ 8'(mks[k]);
        end
    endtask

    function automatic int s_diff_a();
        int c = 0;
        for (int n = 0; n < DA; n++) if (smem_a[n] !== 8'(ms[n])) c++;
        return c;
    endfunction

    function automatic int out_diff_a();
        int c = 0;
        for (int k = 0; k < MA; k++) if (outm_a[k] !== pt_a[k]) c++;
        return c;
    endfunction

    logic       tr_we   [TR];
    logic [7:0] tr_addr [TR];
    logic [7:0] tr_wd   [TR];
    logic       tr_busy [TR];
    logic       tr_done [TR];

    task automatic rec(input int m);
        tr_we[m]   = s_we_a;
        tr_addr[m] = s_addr_a;
        tr_wd[m]   = s_wdata_a;
        tr_busy[m] = busy_a;
        tr_done[m] = done_a;
    endtask

    // m indexes the state just after the m-th rising edge following the accept edge.
    task automatic run_a(input logic [23:0] key, input logic prga, output int lat);
        @(posedge clk); #1;
        key_a = key; prga_a = prga; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; key_a = ~key; prga_a = ~prga;
        lat = -1;
        rec(0);
        for (int m = 1; m < 2150; m++) begin
            @(posedge clk); #1;
            rec(m);
            if (done_a && lat < 0) lat = m;
            if (lat >= 0 && m == lat + 1) break;
        end
    endtask

    int lat, cnt;
    logic [23:0] rk;
    logic [39:0] kb1, kb2;
    logic [7:0]  snap [DA];

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        start_a = 1'b0; prga_a = 1'b0; key_a = '0;
        start_b = 1'b0; prga_b = 1'b0; key_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_s_we", s_we_a, 0);
        chk("rst_s_addr", s_addr_a, 0);
        chk("rst_s_wdata", s_wdata_a, 0);
        chk("rst_rom_addr", rom_addr_a, 0);
        chk("rst_out_we", out_we_a, 0);
        chk("rst_out_addr", out_addr_a, 0);
        chk("rst_out_wdata", out_wdata_a, 0);
        reset = 1'b0;

        // KSA only, all-zero key
        rc4_model(DA, KA, 128'(24'h000000), 0);
        run_a(24'h000000, 1'b0, lat);
        chk("ksa_latency", lat, 1793);
        cnt = 0;
        for (int n = 0; n < 1793; n++) if (tr_busy[n] !== 1'b1 || tr_done[n] !== 1'b0) cnt++;
        chk("ksa_busy_throughout", cnt, 0);
        chk("ksa_done_pulse_end", tr_done[1794], 0);
        chk("ksa_busy_end", tr_busy[1794], 0);
        cnt = 0;
        for (int n = 0; n < DA; n++)
            if (tr_we[n] !== 1'b1 || tr_addr[n] !== 8'(n) || tr_wd[n] !== 8'(n)) cnt++;
        chk("init_fill_writes", cnt, 0);
        chk("init_end_we", tr_we[256], 0);
        chk("ksa_first_rd_addr", tr_addr[257], 0);
        chk("ksa_first_rd_we", tr_we[257], 0);
        chk("ksa_j_iter0", tr_addr[259], 0);
        chk("ksa_j_iter1", tr_addr[265], 1);
        chk("ksa_j_iter2", tr_addr[271], 3);
        chk("ksa_swap2_wr_i", {tr_we[273], tr_addr[273], tr_wd[273]}, {1'b1, 8'd2, 8'd3});
        chk("ksa_swap2_wr_j", {tr_we[274], tr_addr[274], tr_wd[274]}, {1'b1, 8'd3, 8'd2});
        chk("ksa_final_s_key0", s_diff_a(), 0);

        // KSA + PRGA, all-zero key
        rc4_model(DA, KA, 128'(24'h000000), MA);
        load_rom_a();
        run_a(24'h000000, 1'b1, lat);
        chk("prga_latency_key0", lat, 2081);
        chk("prga_plaintext_key0", out_diff_a(), 0);
        chk("prga_final_s_key0", s_diff_a(), 0);

        // KSA + PRGA, random key
        rk = 24'($urandom);
        rc4_model(DA, KA, 128'(rk), MA);
        load_rom_a();
        run_a(rk, 1'b1, lat);
        chk("prga_latency_rnd", lat, 2081);
        chk("prga_plaintext_rnd", out_diff_a(), 0);
        chk("prga_final_s_rnd", s_diff_a(), 0);

        // Asynchronous reset in the middle of the key schedule
        @(posedge clk); #1;
        key_a = 24'($urandom); prga_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (755) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_s_we", s_we_a, 0);
        chk("abort_s_addr", s_addr_a, 0);
        chk("abort_s_wdata", s_wdata_a, 0);
        for (int n = 0; n < DA; n++) snap[n] = smem_a[n];
        cnt = 0;
        for (int m = 0; m < 24; m++) begin
            @(posedge clk); #1;
            if (m == 2) reset = 1'b0;
            if (s_we_a !== 1'b0 || busy_a !== 1'b0) cnt++;
        end
        chk("abort_quiet_after", cnt, 0);
        cnt = 0;
        for (int n = 0; n < DA; n++) if (smem_a[n] !== snap[n]) cnt++;
        chk("abort_no_mem_write", cnt, 0);

        rk = 24'($urandom);
        rc4_model(DA, KA, 128'(rk), MA);
        load_rom_a();
        run_a(rk, 1'b1, lat);
        chk("restart_latency", lat, 2081);
        chk("restart_plaintext", out_diff_a(), 0);
        chk("restart_final_s", s_diff_a(), 0);

        // Small configuration; second start while busy carries a different key
        kb1 = {32'($urandom), 8'($urandom)};
        kb2 = ~kb1;
        rc4_model(DB, KB, 128'(kb1), MB);
        for (int k = 0; k < MB; k++) begin
            pt_b[k]  = 8'($urandom);
            rom_b[k] = pt_b[k] ^ 8'(mks[k]);
        end
        @(posedge clk); #1;
        key_b = kb1; prga_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; key_b = kb2; prga_b = 1'b0;
        lat = -1;
        for (int m = 1; m < 400; m++) begin
            @(posedge clk); #1;
            start_b = (m == 10);
            if (done_b) begin
                lat = m;
                break;
            end
        end
        start_b = 1'b0;
        chk("sweep_latency", lat, 1 + 7 * DB + 9 * MB);
        cnt = 0;
        for (int m = 0; m < 4; m++) begin
            @(posedge clk); #1;
            if (busy_b !== 1'b0 || done_b !== 1'b0) cnt++;
        end
        chk("sweep_second_start_ignored", cnt, 0);
        cnt = 0;
        for (int k = 0; k < MB; k++) if (outm_b[k] !== pt_b[k]) cnt++;
        chk("sweep_plaintext", cnt, 0);
        cnt = 0;
        for (int n = 0; n < DB; n++) if (smem_b[n] !== 8'(ms[n])) cnt++;
        chk("sweep_final_s", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
